execute_stage: RTL

- Execute stage of the RV32I pipeline: accepts decoded ops from the decode/operand-read stage, runs them through one internal `alu` instance, and buffers results for the writeback stage.
- Resolves branches from the ALU compare result and issues a one-cycle fetch redirect.
- Uses an epoch bit so wrong-path ops that follow a taken branch are consumed and dropped.

---
 rtl/execute_stage.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// Execute stage of the RV32I pipeline: one ALU, branch resolution with an
// epoch bit for wrong-path squashing, and a 2-entry output buffer feeding
// writeback.
// Optional build macro: EXECUTE_STAGE_FORWARD_EN adds fwd_valid/fwd_rd/fwd_data
// describing the youngest buffered entry that writes the register file.

package execute_stage_pkg;

  // Codes 14 and 15 are undefined and produce a zero result.
  typedef enum logic [3:0] {
    CMD_ADD  = 4'd0,
    CMD_SUB  = 4'd1,
    CMD_AND  = 4'd2,
    CMD_OR   = 4'd3,
    CMD_XOR  = 4'd4,
    CMD_SLL  = 4'd5,
    CMD_SRL  = 4'd6,
    CMD_SRA  = 4'd7,
    CMD_EQ   = 4'd8,
    CMD_NE   = 4'd9,
    CMD_LT   = 4'd10,
    CMD_GE   = 4'd11,
    CMD_LTU  = 4'd12,
    CMD_GEU  = 4'd13
  } command_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        write;
  } entry_t;

endpackage

module alu
  import execute_stage_pkg::*;
(
  input  command_t    command,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  output logic [31:0] result
);

  // Pure combinational ALU; compares return 0/1 in bit 0.
  always_comb begin
    result = '0;
    case (command)
      CMD_ADD: result = lhs + rhs;
      CMD_SUB: result = lhs - rhs;
      CMD_AND: result = lhs & rhs;
      CMD_OR:  result = lhs | rhs;
      CMD_XOR: result = lhs ^ rhs;
      CMD_SLL: result = lhs << rhs[4:0];
      CMD_SRL: result = lhs >> rhs[4:0];
      CMD_SRA: result = 32'($signed(lhs) >>> rhs[4:0]);
      CMD_EQ:  result = {31'd0, lhs == rhs};
      CMD_NE:  result = {31'd0, lhs != rhs};
      CMD_LT:  result = {31'd0, $signed(lhs) < $signed(rhs)};
      CMD_GE:  result = {31'd0, $signed(lhs) >= $signed(rhs)};
      CMD_LTU: result = {31'd0, lhs < rhs};
      CMD_GEU: result = {31'd0, lhs >= rhs};
      default: result = '0;
    endcase
  end

endmodule

module execute_stage
  import execute_stage_pkg::*;
#(
  parameter logic RESET_EPOCH = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  command_t    in_command,
  input  logic [31:0] in_lhs,
  input  logic [31:0] in_rhs,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_write,
  input  logic        in_is_branch,
  input  logic [31:0] in_link,
  input  logic [31:0] in_target,
  input  logic        in_epoch,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_write,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
`ifdef EXECUTE_STAGE_FORWARD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
`endif
);

  logic [31:0] alu_result;
  logic [1:0]  count;
  logic        epoch;
  entry_t      head;
  entry_t      tail;
  entry_t      new_entry;
  logic        accept;
  logic        push;
  logic        pop;
  logic        taken;

  alu u_alu (
    .command (in_command),
    .lhs     (in_lhs),
    .rhs     (in_rhs),
    .result  (alu_result)
  );

  // Handshake and entry formation; wrong-epoch ops are accepted but not pushed.
  always_comb begin
    in_ready       = (count != 2'd2);
    accept         = in_valid && in_ready;
    push           = accept && (in_epoch == epoch);
    pop            = (count != 2'd0) && wb_ready;
    taken          = push && in_is_branch && alu_result[0];
    new_entry.rd   = in_rd;
    new_entry.data = in_is_branch ? in_link : alu_result;
    new_entry.write = in_rd_write && (in_rd != 5'd0);
  end

  // Writeback view of the head entry, zero when the buffer is empty.
  always_comb begin
    wb_valid = (count != 2'd0);
    wb_rd    = wb_valid ? head.rd    : 5'd0;
    wb_data  = wb_valid ? head.data  : 32'd0;
    wb_write = wb_valid ? head.write : 1'b0;
  end

  // Two-entry buffer: head is oldest; a pop shifts tail into head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= new_entry;
          else               tail <= new_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= new_entry;
          end else begin
            head <= tail;
            tail <= new_entry;
          end
        end
        default: ;
      endcase
    end
  end

  // Taken branch flips the epoch and raises a single-cycle redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      epoch          <= RESET_EPOCH;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      redirect_valid <= taken;
      redirect_pc    <= taken ? in_target : 32'd0;
      if (taken) epoch <= ~epoch;
    end
  end

`ifdef EXECUTE_STAGE_FORWARD_EN
  // Youngest buffered register-writing entry, for decode bypass.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = 5'd0;
    fwd_data  = 32'd0;
    if ((count == 2'd2) && tail.write) begin
      fwd_valid = 1'b1;
      fwd_rd    = tail.rd;
      fwd_data  = tail.data;
    end else if ((count != 2'd0) && head.write) begin
      fwd_valid = 1'b1;
      fwd_rd    = head.rd;
      fwd_data  = head.data;
    end
  end
`endif

endmodule
